// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble/halt encodings, reset PC
// default and the fetch state enumeration.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_imem.sv
// Instruction storage: combinational read, synchronous write, no reset.
// A same-cycle read of the word being written sees the old contents.
module Instruction_memory #(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALT state machine and IF/ID register.
// Priority per edge: reset > branch_taken > halted/stall > normal fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter  int unsigned IMEM_DEPTH = 32,
  parameter  logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter  logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
  localparam int unsigned AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   Instruction_Code,
  output logic [31:0]   PC_plus4,
  output logic          IF_valid,
  output logic          halted
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target_aligned;
  logic [31:0]  fetch_word;

  Instruction_memory #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc[AW+1:2]),
    .rdata (fetch_word)
  );

  assign pc_inc         = pc + 32'd4;
  assign target_aligned = branch_target & ~32'd3;
  assign halted         = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      pc               <= RESET_PC;
      Instruction_Code <= NOP_WORD;
      PC_plus4         <= '0;
      IF_valid         <= 1'b0;
    end else if (branch_taken) begin
      state            <= RUN;
      pc               <= target_aligned;
      Instruction_Code <= NOP_WORD;
      PC_plus4         <= pc_inc;
      IF_valid         <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          // PC frozen on the halt word; bubbles keep flowing regardless of stall
          Instruction_Code <= NOP_WORD;
          PC_plus4         <= pc_inc;
          IF_valid         <= 1'b0;
        end
        default: begin
          if (!stall) begin
            PC_plus4 <= pc_inc;
            if (fetch_word == HALT_WORD) begin
              state            <= HALT;
              Instruction_Code <= NOP_WORD;
              IF_valid         <= 1'b0;
            end else begin
              pc               <= pc_inc;
              Instruction_Code <= fetch_word;
              IF_valid         <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
